// File: rtl/param_scan_mux_pkg.sv
// Shared definitions for the parametrised scanning channel multiplexer.
package param_scan_mux_pkg;

  // Operating modes; the reserved encoding behaves exactly like hold.
  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_RSVD   = 2'b11
  } scan_mode_e;

endpackage : param_scan_mux_pkg

// File: rtl/param_scan_mux_onehot_decoder.sv
// Combinational index-to-one-hot decoder. An index at or beyond CHANNELS
// decodes to all zeros, which downstream logic treats as "no channel".
module onehot_decoder #(
  parameter int SEL_W    = 3,
  parameter int CHANNELS = 8
) (
  input  logic [SEL_W-1:0]    i_idx,
  output logic [CHANNELS-1:0] o_onehot
);

  // Compare the index against every channel number.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // so no path through the block can infer a latch.
    o_onehot = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (i_idx == SEL_W'(k)) o_onehot[k] = 1'b1;
    end
  end

endmodule : onehot_decoder

// File: rtl/param_scan_mux.sv
// N:1 channel multiplexer with a registered output and valid/ready handshake.
// Manual select, round-robin auto-scan over enabled channels, and hold.
module param_scan_mux
  import param_scan_mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d_in,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      scan_done
);

  // Reject inconsistent pointer width or channel count at elaboration.
  if (SEL_W != $clog2(CHANNELS)) begin : g_bad_sel_w
    $error("param_scan_mux: SEL_W must equal clog2(CHANNELS)");
  end
  if (CHANNELS < 2 || CHANNELS > 256) begin : g_bad_channels
    $error("param_scan_mux: CHANNELS must be in 2..256");
  end

  scan_mode_e          w_mode;
  logic [CHANNELS-1:0] w_ptr_oh;
  logic [CHANNELS-1:0] w_lower_mask;
  logic [CHANNELS-1:0] w_upper_en;
  logic [CHANNELS-1:0] w_cap_oh;
  logic [SEL_W-1:0]    w_up_idx;
  logic [SEL_W-1:0]    w_first_idx;
  logic [SEL_W-1:0]    w_last_idx;
  logic [SEL_W-1:0]    w_next_idx;
  logic [SEL_W-1:0]    w_cap_idx;
  logic                w_found_up;
  logic                w_any_en;
  logic                w_cap_ok;
  logic                w_slot_free;
  logic [WIDTH-1:0]    w_cap_data;

  logic                r_valid;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_ch;
  logic                r_scan_done;
  logic [SEL_W-1:0]    r_ptr;

  assign w_mode      = scan_mode_e'(mode);
  assign w_slot_free = !r_valid || out_ready;
  assign w_any_en    = |ch_en;

  // One-hot of the last auto-scanned channel, used to build the lower mask.
  onehot_decoder #(.SEL_W(SEL_W), .CHANNELS(CHANNELS)) u_ptr_dec (
    .i_idx    (r_ptr),
    .o_onehot (w_ptr_oh)
  );

  // lower_mask(ptr): bits 0..ptr set, so the masked search only sees channels above ptr.
  always_comb begin
    logic v_acc;
    v_acc        = 1'b0;
    w_lower_mask = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      v_acc           = v_acc | w_ptr_oh[k];
      w_lower_mask[k] = v_acc;
    end
  end

  assign w_upper_en = ch_en & ~w_lower_mask;

  // Find-first above ptr, find-first overall (wrap fallback) and highest enabled index.
  always_comb begin
    logic v_found;
    v_found     = 1'b0;
    w_up_idx    = '0;
    w_first_idx = '0;
    w_last_idx  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_upper_en[k] && !v_found) begin
        w_up_idx = SEL_W'(k);
        v_found  = 1'b1;
      end
    end
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (ch_en[k]) w_first_idx = SEL_W'(k);
    end
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_en[k]) w_last_idx = SEL_W'(k);
    end
    w_found_up = v_found;
  end

  assign w_next_idx = w_found_up ? w_up_idx : w_first_idx;
  assign w_cap_idx  = (w_mode == MODE_MANUAL) ? sel_in : w_next_idx;

  // One-hot of the channel that would be captured this edge.
  onehot_decoder #(.SEL_W(SEL_W), .CHANNELS(CHANNELS)) u_cap_dec (
    .i_idx    (w_cap_idx),
    .o_onehot (w_cap_oh)
  );

  // Manual selection must hit an in-range, enabled channel; auto needs any enabled channel.
  assign w_cap_ok = (w_mode == MODE_MANUAL) ? |(w_cap_oh & ch_en) : w_any_en;

  // AND-OR data select driven by the capture one-hot.
  always_comb begin
    w_cap_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_cap_data = w_cap_data | (d_in[k*WIDTH +: WIDTH] & {WIDTH{w_cap_oh[k]}});
    end
  end

  // Capture register, scan pointer and handshake: only a free slot may change the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_ch        <= '0;
      r_scan_done <= 1'b0;
      r_ptr       <= SEL_W'(CHANNELS - 1);
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_scan_done <= 1'b0;
      if (w_slot_free) begin
        unique case (w_mode)
          MODE_MANUAL: begin
            r_valid <= w_cap_ok;
            if (w_cap_ok) begin
              r_data <= w_cap_data;
              r_ch   <= sel_in;
            end
          end
          MODE_AUTO: begin
            r_valid <= w_cap_ok;
            if (w_cap_ok) begin
              r_data      <= w_cap_data;
              r_ch        <= w_next_idx;
              r_ptr       <= w_next_idx;
              r_scan_done <= (w_next_idx == w_last_idx);
            end
          end
          default: r_valid <= 1'b0;
        endcase
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign scan_done = r_scan_done;

endmodule : param_scan_mux

// File: tb/tb_param_scan_mux.sv
// Self-checking bench for param_scan_mux: directed scenarios plus a random
// phase, compared against a behavioural model of the selection rules.
module tb_param_scan_mux;
  import param_scan_mux_pkg::*;

  localparam int CH  = 8;
  localparam int W   = 4;
  localparam int CH5 = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH*W-1:0] d_in;
  logic [CH-1:0]   ch_en;
  logic [1:0]      mode;
  logic [2:0]      sel_in;
  logic            out_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [2:0]      out_ch;
  logic            scan_done;

  logic [CH5*W-1:0] d5_in;
  logic [CH5-1:0]   ch5_en;
  logic [1:0]       mode5;
  logic [2:0]       sel5_in;
  logic             o5_valid;
  logic [W-1:0]     o5_data;
  logic [2:0]       o5_ch;
  logic             o5_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_ch;
  bit         m_done;
  int         m_ptr;

  always #5 clk = ~clk;

  param_scan_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_in      (d_in),
    .ch_en     (ch_en),
    .mode      (mode),
    .sel_in    (sel_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .scan_done (scan_done)
  );

  param_scan_mux #(.WIDTH(W), .CHANNELS(CH5), .SEL_W(3)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_in      (d5_in),
    .ch_en     (ch5_en),
    .mode      (mode5),
    .sel_in    (sel5_in),
    .out_ready (1'b1),
    .out_valid (o5_valid),
    .out_data  (o5_data),
    .out_ch    (o5_ch),
    .scan_done (o5_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_done  = 1'b0;
    m_ptr   = CH - 1;
  endtask

  // One clock edge of the behavioural model, using the inputs present before the edge.
  task automatic model_edge();
    bit done_n;
    int nxt;
    int top;
    int c;
    done_n = 1'b0;
    nxt    = -1;
    top    = -1;
    if (!m_valid || out_ready) begin
      case (mode)
        2'b00: begin
          if (int'(sel_in) < CH && ch_en[sel_in]) begin
            m_valid = 1'b1;
            m_data  = d_in[int'(sel_in)*W +: W];
            m_ch    = int'(sel_in);
          end else begin
            m_valid = 1'b0;
          end
        end
        2'b01: begin
          // Rotate through the channels starting just after the pointer.
          for (int i = 1; i <= CH; i++) begin
            c = (m_ptr + i) % CH;
            if (ch_en[c] && nxt < 0) nxt = c;
          end
          for (int k = 0; k < CH; k++) if (ch_en[k]) top = k;
          if (nxt >= 0) begin
            m_valid = 1'b1;
            m_data  = d_in[nxt*W +: W];
            m_ch    = nxt;
            m_ptr   = nxt;
            done_n  = (nxt == top);
          end else begin
            m_valid = 1'b0;
          end
        end
        default: m_valid = 1'b0;
      endcase
    end
    m_done = done_n;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, "_data"}, 32'(out_data), 32'(m_data));
    check({tag, "_done"}, 32'(scan_done), 32'(m_done));
    if (m_valid) check({tag, "_ch"}, 32'(out_ch), 32'(m_ch));
  endtask

  task automatic set_counting_data();
    for (int k = 0; k < CH; k++) d_in[k*W +: W] = W'(k + 1);
    for (int k = 0; k < CH5; k++) d5_in[k*W +: W] = W'(k + 1);
  endtask

  int exp_seq[6] = '{0, 2, 5, 7, 0, 2};

  initial begin
    rst_n     = 1'b0;
    ch_en     = 8'hFF;
    mode      = MODE_HOLD;
    sel_in    = 3'd0;
    out_ready = 1'b1;
    ch5_en    = 5'h1F;
    mode5     = MODE_HOLD;
    sel5_in   = 3'd0;
    set_counting_data();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    check("rst_done", 32'(scan_done), 32'd0);
    rst_n = 1'b1;

    // Manual select of channel 5
    mode   = MODE_MANUAL;
    sel_in = 3'd5;
    tick("t1");
    check("t1_data_abs", 32'(out_data), 32'h6);
    check("t1_ch_abs", 32'(out_ch), 32'd5);

    // Auto-scan over a sparse mask
    mode  = MODE_AUTO;
    ch_en = 8'b1010_0101;
    for (int i = 0; i < 6; i++) begin
      tick("t2");
      check("t2_seq_ch", 32'(out_ch), 32'(exp_seq[i]));
      check("t2_seq_done", 32'(scan_done), 32'(exp_seq[i] == 7));
    end

    // Stall the consumer after a capture of channel 0
    repeat (3) tick("t3_pre");
    check("t3_start_ch", 32'(out_ch), 32'd0);
    out_ready = 1'b0;
    repeat (3) tick("t3_stall");
    check("t3_hold_ch", 32'(out_ch), 32'd0);
    check("t3_hold_data", 32'(out_data), 32'h1);
    out_ready = 1'b1;
    tick("t3_release");
    check("t3_next_ch", 32'(out_ch), 32'd2);
    check("t3_next_valid", 32'(out_valid), 32'd1);

    // Mask cleared while a sample is pending
    out_ready = 1'b0;
    ch_en     = 8'h00;
    repeat (2) tick("t4_pend");
    check("t4_pend_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick("t4_accept");
    check("t4_drop_valid", 32'(out_valid), 32'd0);
    ch_en = 8'h10;
    tick("t4_restore");
    check("t4_restore_ch", 32'(out_ch), 32'd4);

    // Five-channel instance: out-of-range manual select
    mode5   = MODE_MANUAL;
    sel5_in = 3'd2;
    tick("t5_a");
    check("t5_cap_valid", 32'(o5_valid), 32'd1);
    check("t5_cap_data", 32'(o5_data), 32'h3);
    sel5_in = 3'd6;
    tick("t5_b");
    check("t5_oor_valid", 32'(o5_valid), 32'd0);
    check("t5_oor_data", 32'(o5_data), 32'h3);
    sel5_in = 3'd4;
    tick("t5_c");
    check("t5_ch4_valid", 32'(o5_valid), 32'd1);
    check("t5_ch4_ch", 32'(o5_ch), 32'd4);
    check("t5_ch4_data", 32'(o5_data), 32'h5);

    // Reset pulsed mid-cycle while a sample is stalled
    ch_en = 8'b0110_0100;
    tick("t6_cap");
    out_ready = 1'b0;
    tick("t6_stall");
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    check("t6_rst_ch", 32'(out_ch), 32'd0);
    check("t6_rst_done", 32'(scan_done), 32'd0);
    model_reset();
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick("t6_first");
    check("t6_first_ch", 32'(out_ch), 32'd2);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      d_in = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      ch_en     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      sel_in    = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_param_scan_mux
